// File: rtl/uart_rx_fifo.sv
// Purpose: 8N1 UART receiver (2-flop synchroniser, mid-bit sampling) feeding a small show-ahead FIFO.
// Latency: a byte is visible on rx_data/rx_valid one cycle after its stop bit is sampled.
// Backpressure: consumer stalls via rx_ready; a good byte arriving at a full, non-popping FIFO is dropped with an overrun pulse.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int HALF = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Synchroniser
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic rxs;

    // Receiver
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          push;

    // FIFO
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          pop;
    logic          full;

    assign rxs       = sync2_q;
    assign rx_valid  = (count_q != '0);
    assign rx_data   = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign pop       = rx_valid & rx_ready;
    assign full      = (count_q == FULL_CNT);
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != S_IDLE);

    // Two-stage shift of the asynchronous line; idles high.
    always_comb begin
        sync1_d = rx;
        sync2_d = sync1_q;
    end

    // Receive FSM: start validation, mid-bit data sampling, stop-bit verdict.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxs ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d   = '0;
                    shreg_d = {rxs, shreg_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (!rxs) begin
                        ferr_d = 1'b1;
                    end else if (!full || pop) begin
                        push = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FIFO pointer and occupancy update; push and pop may coincide even when full.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shreg_q  <= '0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since rx_data is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= shreg_q;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Purpose: randomized and directed checks of uart_rx_fifo against a queue-based reference model.
// Latency: model expects a byte visible 79 cycles after the start-bit drive (2 sync + 77 frame).
// Backpressure: rx_ready is held, pulsed, or randomized; the model pops whenever valid and ready.
module tb_uart_rx_fifo;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;

    logic       clk;
    logic       reset_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] mq [$];
    logic       e_ferr;
    logic       e_ovr;
    logic       exp_busy;
    logic       ev_pend;
    logic [7:0] ev_byte;
    logic       ev_stop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock, update the model for that edge, compare all outputs.
    task automatic tick();
        logic was_full;
        logic do_pop;
        @(posedge clk);
        #1;
        e_ferr = 1'b0;
        e_ovr  = 1'b0;
        if (!reset_n) begin
            mq.delete();
        end else begin
            was_full = (mq.size() == DEPTH);
            do_pop   = rx_ready && (mq.size() != 0);
            if (do_pop) void'(mq.pop_front());
            if (ev_pend) begin
                if (!ev_stop)                e_ferr = 1'b1;
                else if (!was_full || do_pop) mq.push_back(ev_byte);
                else                         e_ovr = 1'b1;
            end
        end
        ev_pend = 1'b0;
        chk("rx_valid",  32'(rx_valid),  32'(mq.size() != 0));
        chk("rx_data",   32'(rx_data),   32'((mq.size() != 0) ? mq[0] : 8'h00));
        chk("frame_err", 32'(frame_err), 32'(e_ferr));
        chk("overrun",   32'(overrun),   32'(e_ovr));
        chk("busy",      32'(busy),      32'(exp_busy));
    endtask

    task automatic idle(input int n);
        exp_busy = 1'b0;
        repeat (n) tick();
    endtask

    // mode 0: rx_ready untouched; 1: rx_ready pulsed on stop-sample cycle; 2: random rx_ready.
    // abort_j >= 0: assert reset for one cycle after tick abort_j and stop the frame.
    task automatic send_frame(input logic [7:0] b, input logic stopb, input int mode, input int abort_j);
        int last_j;
        last_j = stopb ? 80 : 84;
        rx = 1'b0;
        for (int j = 1; j <= last_j; j++) begin
            int k;
            exp_busy = ((j >= 3 && j <= 78) || (!stopb && j >= 80 && j <= 83))
                       && !(abort_j >= 0 && j > abort_j);
            ev_pend  = (j == 79);
            ev_byte  = b;
            ev_stop  = stopb;
            tick();
            if (abort_j >= 0 && j == abort_j + 1) begin
                reset_n = 1'b1;
                rx      = 1'b1;
                break;
            end
            if (abort_j >= 0 && j == abort_j) reset_n = 1'b0;
            k  = j / CPB;
            rx = (k == 0) ? 1'b0 : (k <= 8) ? b[3'(k - 1)] : (k == 9) ? stopb : 1'b1;
            if (mode == 1) begin
                if (j == 78) rx_ready = 1'b1;
                if (j == 79) rx_ready = 1'b0;
            end else if (mode == 2) begin
                rx_ready = 1'($urandom_range(0, 1));
            end
        end
        exp_busy = 1'b0;
    endtask

    task automatic drain();
        rx_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH && mq.size() != 0; i++) tick();
        rx_ready = 1'b0;
        tick();
        chk("drain_empty", 32'(rx_valid), 32'(0));
    endtask

    initial begin
        logic [7:0] rb;
        logic       rs;
        reset_n  = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b0;
        exp_busy = 1'b0;
        ev_pend  = 1'b0;
        ev_byte  = 8'h00;
        ev_stop  = 1'b1;
        e_ferr   = 1'b0;
        e_ovr    = 1'b0;

        // Reset state
        idle(3);
        reset_n = 1'b1;
        idle(4);

        // 1: single byte, held until the consumer is ready
        send_frame(8'hA5, 1'b1, 0, -1);
        idle(10);
        drain();

        // 2: false start (2-cycle low glitch)
        rx = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            exp_busy = (j >= 3 && j <= 6);
            tick();
            if (j == 1) rx = 1'b1;
        end
        exp_busy = 1'b0;
        idle(4);

        // 3: framing error
        send_frame(8'h3C, 1'b0, 0, -1);
        idle(6);

        // 4: overflow with five back-to-back bytes
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0, -1);
        idle(4);
        drain();

        // 5: full FIFO, pop coincides with the push of 0x77
        for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1'b1, 0, -1);
        send_frame(8'h77, 1'b1, 1, -1);
        idle(4);
        drain();

        // 6: reset during data bit 3, then a clean frame
        send_frame(8'hC3, 1'b1, 0, 36);
        idle(6);
        send_frame(8'h5A, 1'b1, 0, -1);
        idle(2);
        drain();

        // Random bytes, random stop bits, random backpressure
        for (int n = 0; n < 10; n++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            send_frame(rb, rs, 2, -1);
            if (!rs) idle(4);
        end
        idle(4);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
